// File: rtl/run_detect_ctrl.sv
// ---------------------------------------------------------------------------
// run_detect_ctrl
//
// Sequences a programmable run-length detector on a serial bit stream.
// START arms scanning and latches the run length (clamped to at least 2) and
// the polarity mode. STOP disarms it. Each qualifying run of equal bits is
// reported once through a valid/ack handshake. The block also keeps a
// saturating event counter and a sticky overrun flag.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous, active-low reset
//   START      arm pulse (accepted only in IDLE without STOP)
//   STOP       disarm pulse
//   RUN_LEN    required run length, sampled on an accepted START
//   MODE       00 ones only, 01 zeros only, 1x either polarity
//   IN         serial data bit
//   EVT_ACK    consumer acknowledge of the pending event
//   EVT_VALID  event pending
//   EVT_POL    polarity of the reported run (1 = ones)
//   EVT_COUNT  detections since START, saturating
//   OVERRUN    sticky, an event arrived while one was still pending
//   BUSY       controller is not IDLE
// ---------------------------------------------------------------------------
module run_detect_ctrl #(
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic [CNT_W-1:0] RUN_LEN,
    input  logic [1:0]       MODE,
    input  logic             IN,
    input  logic             EVT_ACK,
    output logic             EVT_VALID,
    output logic             EVT_POL,
    output logic [EVT_W-1:0] EVT_COUNT,
    output logic             OVERRUN,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(2);
    localparam logic [EVT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len, len_nxt;
    logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
    logic [1:0]       mode, mode_nxt;
    logic             prev_bit, prev_bit_nxt;
    logic             fired, fired_nxt;
    logic             evt_valid_nxt, evt_pol_nxt, overrun_nxt;
    logic [EVT_W-1:0] evt_count_nxt;

    logic same_bit, pol_ok, detect, ack_pending;

    // All state lives here; BUSY is decoded from the next state so it is a
    // clean registered output aligned with the state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            len       <= '0;
            run_cnt   <= '0;
            mode      <= '0;
            prev_bit  <= 1'b0;
            fired     <= 1'b0;
            EVT_VALID <= 1'b0;
            EVT_POL   <= 1'b0;
            EVT_COUNT <= '0;
            OVERRUN   <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            run_cnt   <= run_cnt_nxt;
            mode      <= mode_nxt;
            prev_bit  <= prev_bit_nxt;
            fired     <= fired_nxt;
            EVT_VALID <= evt_valid_nxt;
            EVT_POL   <= evt_pol_nxt;
            EVT_COUNT <= evt_count_nxt;
            OVERRUN   <= overrun_nxt;
            BUSY      <= (state_nxt != IDLE);
        end
    end

    // Next-state and datapath. A detection is the edge where the run counter
    // reaches len; since the counter saturates at len, this happens at most
    // once per run, and 'fired' additionally guards against a refire.
    always_comb begin
        state_nxt     = state;
        len_nxt       = len;
        run_cnt_nxt   = run_cnt;
        mode_nxt      = mode;
        prev_bit_nxt  = prev_bit;
        fired_nxt     = fired;
        evt_valid_nxt = EVT_VALID;
        evt_pol_nxt   = EVT_POL;
        evt_count_nxt = EVT_COUNT;
        overrun_nxt   = OVERRUN;

        same_bit    = (IN == prev_bit);
        pol_ok      = mode[1] | (mode[0] ? ~IN : IN);
        ack_pending = EVT_VALID & EVT_ACK;
        detect      = (state == SCAN) && !STOP && same_bit && !fired &&
                      (run_cnt == (len - ONE)) && pol_ok;

        case (state)
            IDLE: begin
                if (START && !STOP) begin
                    state_nxt     = PRIME;
                    len_nxt       = (RUN_LEN < MIN_LEN) ? MIN_LEN : RUN_LEN;
                    mode_nxt      = MODE;
                    evt_count_nxt = '0;
                    overrun_nxt   = 1'b0;
                    evt_valid_nxt = 1'b0;
                    evt_pol_nxt   = 1'b0;
                end
            end

            PRIME: begin
                if (STOP) begin
                    state_nxt = IDLE;
                end else begin
                    prev_bit_nxt = IN;
                    run_cnt_nxt  = ONE;
                    fired_nxt    = 1'b0;
                    state_nxt    = SCAN;
                end
            end

            SCAN: begin
                if (STOP) begin
                    // The sample of this cycle is discarded; only a pending
                    // event that is not acked right now keeps us busy.
                    if (ack_pending) begin
                        evt_valid_nxt = 1'b0;
                    end
                    state_nxt = (EVT_VALID && !EVT_ACK) ? DRAIN : IDLE;
                end else begin
                    if (same_bit) begin
                        if (run_cnt != len) begin
                            run_cnt_nxt = run_cnt + ONE;
                        end
                    end else begin
                        run_cnt_nxt  = ONE;
                        fired_nxt    = 1'b0;
                        prev_bit_nxt = IN;
                    end

                    if (detect) begin
                        fired_nxt = 1'b1;
                        if (EVT_COUNT != CNT_MAX) begin
                            evt_count_nxt = EVT_COUNT + 1'b1;
                        end
                        // An ack on the same edge frees the slot for the new event.
                        if (!EVT_VALID || EVT_ACK) begin
                            evt_valid_nxt = 1'b1;
                            evt_pol_nxt   = IN;
                        end else begin
                            overrun_nxt = 1'b1;
                        end
                    end else if (ack_pending) begin
                        evt_valid_nxt = 1'b0;
                    end
                end
            end

            DRAIN: begin
                if (EVT_ACK) begin
                    evt_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_detect_ctrl
//
// Self-checking bench for run_detect_ctrl. A table of per-cycle stimulus
// records with hand-derived expected outputs drives the main scenarios;
// expected outputs go into a scoreboard queue when a cycle is driven and are
// popped and compared one cycle later, after the edge. Hand-written sequences
// cover counter saturation and asynchronous reset mid-scan.
// ---------------------------------------------------------------------------
module tb_run_detect_ctrl;

    localparam int CNT_W = 4;
    localparam int EVT_W = 8;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic [CNT_W-1:0] RUN_LEN = '0;
    logic [1:0]       MODE = '0;
    logic             IN = 1'b0;
    logic             EVT_ACK = 1'b0;
    logic             EVT_VALID;
    logic             EVT_POL;
    logic [EVT_W-1:0] EVT_COUNT;
    logic             OVERRUN;
    logic             BUSY;

    run_detect_ctrl #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .STOP      (STOP),
        .RUN_LEN   (RUN_LEN),
        .MODE      (MODE),
        .IN        (IN),
        .EVT_ACK   (EVT_ACK),
        .EVT_VALID (EVT_VALID),
        .EVT_POL   (EVT_POL),
        .EVT_COUNT (EVT_COUNT),
        .OVERRUN   (OVERRUN),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string            name;
        logic             start;
        logic             stop;
        logic [CNT_W-1:0] run_len;
        logic [1:0]       mode;
        logic             in_bit;
        logic             ack;
        logic             exp_valid;
        logic             exp_pol;
        logic [EVT_W-1:0] exp_count;
        logic             exp_ovr;
        logic             exp_busy;
    } vec_t;

    typedef struct {
        string            name;
        logic             valid;
        logic             pol;
        logic [EVT_W-1:0] count;
        logic             ovr;
        logic             busy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    function automatic vec_t mkVec(input string name, input logic start, input logic stop,
                                   input logic [CNT_W-1:0] run_len, input logic [1:0] mode,
                                   input logic in_bit, input logic ack,
                                   input logic exp_valid, input logic exp_pol,
                                   input logic [EVT_W-1:0] exp_count,
                                   input logic exp_ovr, input logic exp_busy);
        vec_t v;
        v.name      = name;
        v.start     = start;
        v.stop      = stop;
        v.run_len   = run_len;
        v.mode      = mode;
        v.in_bit    = in_bit;
        v.ack       = ack;
        v.exp_valid = exp_valid;
        v.exp_pol   = exp_pol;
        v.exp_count = exp_count;
        v.exp_ovr   = exp_ovr;
        v.exp_busy  = exp_busy;
        return v;
    endfunction

    task automatic addVec(input string name, input logic start, input logic stop,
                          input logic [CNT_W-1:0] run_len, input logic [1:0] mode,
                          input logic in_bit, input logic ack,
                          input logic exp_valid, input logic exp_pol,
                          input logic [EVT_W-1:0] exp_count,
                          input logic exp_ovr, input logic exp_busy);
        vecs.push_back(mkVec(name, start, stop, run_len, mode, in_bit, ack,
                             exp_valid, exp_pol, exp_count, exp_ovr, exp_busy));
    endtask

    task automatic pushExpect(input string name, input logic valid, input logic pol,
                              input logic [EVT_W-1:0] count, input logic ovr,
                              input logic busy);
        exp_t e;
        e.name  = name;
        e.valid = valid;
        e.pol   = pol;
        e.count = count;
        e.ovr   = ovr;
        e.busy  = busy;
        exp_q.push_back(e);
    endtask

    // Pops the oldest expectation and compares it against the live outputs.
    task automatic checkOutput();
        exp_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: no expectation queued at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if ({EVT_VALID, EVT_POL, EVT_COUNT, OVERRUN, BUSY} !==
                {e.valid, e.pol, e.count, e.ovr, e.busy}) begin
                mismatched++;
                $display("[TB] FAIL %s: got valid=%0b pol=%0b count=%0d ovr=%0b busy=%0b, want valid=%0b pol=%0b count=%0d ovr=%0b busy=%0b",
                         e.name, EVT_VALID, EVT_POL, EVT_COUNT, OVERRUN, BUSY,
                         e.valid, e.pol, e.count, e.ovr, e.busy);
            end
        end
    endtask

    // Drives one cycle of inputs, queues the outputs expected after the next
    // rising edge, then samples 1 time unit past that edge.
    task automatic applyStimulus(input vec_t v);
        START   = v.start;
        STOP    = v.stop;
        RUN_LEN = v.run_len;
        MODE    = v.mode;
        IN      = v.in_bit;
        EVT_ACK = v.ack;
        pushExpect(v.name, v.exp_valid, v.exp_pol, v.exp_count, v.exp_ovr, v.exp_busy);
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    initial begin : main
        logic             sat_pol;
        logic [EVT_W-1:0] sat_cnt;
        logic             b;

        // Reset state while RESET is held low.
        #12;
        pushExpect("reset_hold", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput();
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Ones run, len 4, either polarity: one event, no refire.
        addVec("t2_start",   1,0,4,2'b10,0,0, 0,0,0,0,1);
        addVec("t2_prime",   0,0,4,2'b10,0,0, 0,0,0,0,1);
        addVec("t2_one1",    0,0,4,2'b10,1,0, 0,0,0,0,1);
        addVec("t2_one2",    0,0,4,2'b10,1,0, 0,0,0,0,1);
        addVec("t2_one3",    0,0,4,2'b10,1,0, 0,0,0,0,1);
        addVec("t2_one4",    0,0,4,2'b10,1,0, 1,1,1,0,1);
        addVec("t2_one5",    0,0,4,2'b10,1,0, 1,1,1,0,1);
        addVec("t2_zero",    0,0,4,2'b10,0,0, 1,1,1,0,1);
        addVec("t2_ack",     0,0,4,2'b10,0,1, 0,1,1,0,1);
        addVec("t2_stop",    0,1,4,2'b10,0,0, 0,1,1,0,0);
        // Ones only, len 3: zeros run ignored.
        addVec("t3_start",   1,0,3,2'b00,0,0, 0,0,0,0,1);
        addVec("t3_prime",   0,0,3,2'b00,0,0, 0,0,0,0,1);
        addVec("t3_z2",      0,0,3,2'b00,0,0, 0,0,0,0,1);
        addVec("t3_z3",      0,0,3,2'b00,0,0, 0,0,0,0,1);
        addVec("t3_z4",      0,0,3,2'b00,0,0, 0,0,0,0,1);
        addVec("t3_o1",      0,0,3,2'b00,1,0, 0,0,0,0,1);
        addVec("t3_o2",      0,0,3,2'b00,1,0, 0,0,0,0,1);
        addVec("t3_o3",      0,0,3,2'b00,1,0, 1,1,1,0,1);
        addVec("t3_ack",     0,0,3,2'b00,1,1, 0,1,1,0,1);
        addVec("t3_stop",    0,1,3,2'b00,0,0, 0,1,1,0,0);
        // len 2, unacked second event: overrun, first event held.
        addVec("t4_start",   1,0,2,2'b10,0,0, 0,0,0,0,1);
        addVec("t4_prime",   0,0,2,2'b10,1,0, 0,0,0,0,1);
        addVec("t4_one2",    0,0,2,2'b10,1,0, 1,1,1,0,1);
        addVec("t4_zero1",   0,0,2,2'b10,0,0, 1,1,1,0,1);
        addVec("t4_zero2",   0,0,2,2'b10,0,0, 1,1,2,1,1);
        addVec("t4_ack",     0,0,2,2'b10,0,1, 0,1,2,1,1);
        addVec("t4_stop",    0,1,2,2'b10,0,0, 0,1,2,1,0);
        // RUN_LEN 0 clamps to 2, zeros only; STOP while pending goes to DRAIN.
        addVec("t5_start",   1,0,0,2'b01,0,0, 0,0,0,0,1);
        addVec("t5_prime",   0,0,0,2'b01,0,0, 0,0,0,0,1);
        addVec("t5_zero2",   0,0,0,2'b01,0,0, 1,0,1,0,1);
        addVec("t5_stop",    0,1,0,2'b01,0,0, 1,0,1,0,1);
        addVec("t5_drain",   1,0,3,2'b00,1,0, 1,0,1,0,1);
        addVec("t5_ack",     0,0,0,2'b01,0,1, 0,0,1,0,0);
        // Same-edge cases.
        addVec("t6_start",   1,0,2,2'b10,0,0, 0,0,0,0,1);
        addVec("t6_prime",   0,0,2,2'b10,1,0, 0,0,0,0,1);
        addVec("t6_one2",    0,0,2,2'b10,1,0, 1,1,1,0,1);
        addVec("t6_zero1",   0,0,2,2'b10,0,0, 1,1,1,0,1);
        addVec("t6_zero2ack",0,0,2,2'b10,0,1, 1,0,2,0,1);
        addVec("t6_startscan",1,0,5,2'b00,1,0, 1,0,2,0,1);
        addVec("t6_one2b",   0,0,2,2'b10,1,0, 1,0,3,1,1);
        addVec("t6_stopack", 0,1,2,2'b10,1,1, 0,0,3,1,0);
        addVec("t6_startstop",1,1,2,2'b10,0,0, 0,0,3,1,0);
        addVec("t6_idle",    0,0,2,2'b10,1,0, 0,0,3,1,0);
        addVec("t6_idleack", 0,0,2,2'b10,1,1, 0,0,3,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Counter saturation: pairs 11,00,11,... each give one detection,
        // acked on the same edge, 260 detections in total.
        applyStimulus(mkVec("sat_start", 1,0,2,2'b10,0,1, 0,0,0,0,1));
        applyStimulus(mkVec("sat_prime", 0,0,2,2'b10,0,1, 0,0,0,0,1));
        sat_pol = 1'b0;
        sat_cnt = '0;
        b = 1'b1;
        for (int k = 0; k < 260; k++) begin
            applyStimulus(mkVec("sat_first", 0,0,2,2'b10,b,1, 0,sat_pol,sat_cnt,0,1));
            if (sat_cnt != 8'hFF) sat_cnt = sat_cnt + 8'd1;
            sat_pol = b;
            applyStimulus(mkVec("sat_det", 0,0,2,2'b10,b,1, 1,sat_pol,sat_cnt,0,1));
            b = ~b;
        end
        applyStimulus(mkVec("sat_stop", 0,1,2,2'b10,0,1, 0,sat_pol,8'hFF,0,0));

        // Asynchronous reset mid-scan with an event pending.
        applyStimulus(mkVec("r_start", 1,0,2,2'b10,0,0, 0,0,0,0,1));
        applyStimulus(mkVec("r_prime", 0,0,2,2'b10,1,0, 0,0,0,0,1));
        applyStimulus(mkVec("r_det",   0,0,2,2'b10,1,0, 1,1,1,0,1));
        #2;
        RESET = 1'b0;
        #1;
        pushExpect("reset_async", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput();
        @(posedge CLK);
        #1;
        pushExpect("reset_held", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput();
        RESET = 1'b1;
        applyStimulus(mkVec("r_idle", 0,0,2,2'b10,1,0, 0,0,0,0,0));
        applyStimulus(mkVec("r_idle2", 0,0,2,2'b10,1,0, 0,0,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "[TB] timeout");
    end

endmodule
